// File: rtl/pulse_timer_seq_if.sv
// Bus bundle between the pulse-channel core and its surroundings (CPU regs,
// frame counter strobes, sweep unit, envelope/mixer).
interface pulse_timer_seq_if;
  logic        cpu_clk_en;
  logic        apu_clk_en;
  logic        half_clk_en;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        channel_en;
  logic        sweep_change;
  logic [10:0] sweep_period;
  logic        sweep_mute;
  logic [10:0] timer_period;
  logic        sweep_enable;
  logic        sweep_negate;
  logic [2:0]  sweep_div_period;
  logic [2:0]  sweep_shift;
  logic        sweep_load;
  logic [5:0]  env_ctl;
  logic        env_start;
  logic        length_nonzero;
  logic        pulse_on;

  modport master (
    output cpu_clk_en, apu_clk_en, half_clk_en, reg_we, reg_addr, reg_data,
           channel_en, sweep_change, sweep_period, sweep_mute,
    input  timer_period, sweep_enable, sweep_negate, sweep_div_period,
           sweep_shift, sweep_load, env_ctl, env_start, length_nonzero, pulse_on
  );

  modport slave (
    input  cpu_clk_en, apu_clk_en, half_clk_en, reg_we, reg_addr, reg_data,
           channel_en, sweep_change, sweep_period, sweep_mute,
    output timer_period, sweep_enable, sweep_negate, sweep_div_period,
           sweep_shift, sweep_load, env_ctl, env_start, length_nonzero, pulse_on
  );
endinterface

// File: rtl/pulse_timer_seq.sv
// Pulse-channel core: register decode, period timer, 8-step duty sequencer,
// length counter and gated pulse output. Optional macro: PULSE_LEN_WRITE_QUIRK_EN.
module pulse_timer_seq #(
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              rst,
  pulse_timer_seq_if.slave bus
);

  logic [1:0]       duty_q, duty_d;
  logic [5:0]       env_ctl_q, env_ctl_d;
  logic             sweep_enable_q, sweep_enable_d;
  logic             sweep_negate_q, sweep_negate_d;
  logic [2:0]       sweep_div_q, sweep_div_d;
  logic [2:0]       sweep_shift_q, sweep_shift_d;
  logic             sweep_load_q, sweep_load_d;
  logic             env_start_q, env_start_d;
  logic [10:0]      period_q, period_d;
  logic [10:0]      timer_q, timer_d;
  logic [2:0]       step_q, step_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic             pulse_on_q, pulse_on_d;

  logic       wr_en, wr0, wr1, wr2, wr3;
  logic       len_dec, load_blocked;
  logic [7:0] duty_pattern;
  logic       duty_bit;

  function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
    logic [7:0] v;
    v = 8'd0;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   5'd31: v = 8'd30;
      default: v = 8'd0;
    endcase
    return LEN_W'(v);
  endfunction

  assign wr_en = bus.reg_we & bus.cpu_clk_en;
  assign wr0   = wr_en & (bus.reg_addr == 2'd0);
  assign wr1   = wr_en & (bus.reg_addr == 2'd1);
  assign wr2   = wr_en & (bus.reg_addr == 2'd2);
  assign wr3   = wr_en & (bus.reg_addr == 2'd3);

  // Patterns are written step 0 in the MSB, so step s reads bit 7-s.
  always_comb begin
    duty_pattern = 8'b01000000;
    case (duty_q)
      2'd0: duty_pattern = 8'b01000000;
      2'd1: duty_pattern = 8'b01100000;
      2'd2: duty_pattern = 8'b01111000;
      2'd3: duty_pattern = 8'b10011111;
      default: duty_pattern = 8'b01000000;
    endcase
  end
  assign duty_bit = duty_pattern[3'd7 - step_q];

  assign len_dec = bus.half_clk_en & ~env_ctl_q[5] & (length_q != '0);
`ifdef PULSE_LEN_WRITE_QUIRK_EN
  assign load_blocked = len_dec;
`else
  assign load_blocked = 1'b0;
`endif

  always_comb begin
    duty_d         = duty_q;
    env_ctl_d      = env_ctl_q;
    sweep_enable_d = sweep_enable_q;
    sweep_negate_d = sweep_negate_q;
    sweep_div_d    = sweep_div_q;
    sweep_shift_d  = sweep_shift_q;
    sweep_load_d   = 1'b0;
    env_start_d    = 1'b0;
    period_d       = period_q;
    timer_d        = timer_q;
    step_d         = step_q;
    length_d       = length_q;

    if (wr0) begin
      duty_d    = bus.reg_data[7:6];
      env_ctl_d = bus.reg_data[5:0];
    end
    if (wr1) begin
      sweep_enable_d = bus.reg_data[7];
      sweep_div_d    = bus.reg_data[6:4];
      sweep_negate_d = bus.reg_data[3];
      sweep_shift_d  = bus.reg_data[2:0];
      sweep_load_d   = 1'b1;
    end

    // CPU period writes take priority over the sweep unit's update.
    if (wr2) period_d[7:0] = bus.reg_data;
    if (wr3) period_d[10:8] = bus.reg_data[2:0];
    if (!wr2 && !wr3 && bus.sweep_change) period_d = bus.sweep_period;

    if (bus.apu_clk_en) begin
      if (timer_q == 11'd0) begin
        timer_d = period_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end
    if (wr3) begin
      step_d      = 3'd0;
      env_start_d = 1'b1;
    end

    if (!bus.channel_en)            length_d = '0;
    else if (wr3 && !load_blocked)  length_d = len_lookup(bus.reg_data[7:3]);
    else if (len_dec)               length_d = length_q - LEN_W'(1);

    pulse_on_d = duty_bit & (length_q != '0) & ~bus.sweep_mute;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q         <= '0;
      env_ctl_q      <= '0;
      sweep_enable_q <= 1'b0;
      sweep_negate_q <= 1'b0;
      sweep_div_q    <= '0;
      sweep_shift_q  <= '0;
      sweep_load_q   <= 1'b0;
      env_start_q    <= 1'b0;
      period_q       <= '0;
      timer_q        <= '0;
      step_q         <= '0;
      length_q       <= '0;
      pulse_on_q     <= 1'b0;
    end else begin
      duty_q         <= duty_d;
      env_ctl_q      <= env_ctl_d;
      sweep_enable_q <= sweep_enable_d;
      sweep_negate_q <= sweep_negate_d;
      sweep_div_q    <= sweep_div_d;
      sweep_shift_q  <= sweep_shift_d;
      sweep_load_q   <= sweep_load_d;
      env_start_q    <= env_start_d;
      period_q       <= period_d;
      timer_q        <= timer_d;
      step_q         <= step_d;
      length_q       <= length_d;
      pulse_on_q     <= pulse_on_d;
    end
  end

  assign bus.timer_period     = period_q;
  assign bus.sweep_enable     = sweep_enable_q;
  assign bus.sweep_negate     = sweep_negate_q;
  assign bus.sweep_div_period = sweep_div_q;
  assign bus.sweep_shift      = sweep_shift_q;
  assign bus.sweep_load       = sweep_load_q;
  assign bus.env_ctl          = env_ctl_q;
  assign bus.env_start        = env_start_q;
  assign bus.length_nonzero   = (length_q != '0);
  assign bus.pulse_on         = pulse_on_q;

endmodule

// File: tb/tb_pulse_timer_seq.sv
// Directed bench for pulse_timer_seq: expected values queued when stimulus is
// driven, popped and compared once the DUT output is due.
module tb_pulse_timer_seq;
  logic clk = 1'b0;
  logic rst;
  logic apu_phase = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  pulse_timer_seq_if bus();
  pulse_timer_seq #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // One CPU cycle; the APU strobe fires on every second one.
  task automatic tick();
    bus.apu_clk_en = apu_phase;
    apu_phase = ~apu_phase;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("check %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    bus.reg_we   = 1'b1;
    bus.reg_addr = a;
    bus.reg_data = d;
    tick();
    bus.reg_we   = 1'b0;
  endtask

  task automatic half_pulse();
    bus.half_clk_en = 1'b1;
    tick();
    bus.half_clk_en = 1'b0;
  endtask

  task automatic run_until(input logic lvl, input int limit, output int n);
    n = 0;
    while (bus.pulse_on !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    expect_val({tag, "_period"}, 32'h0);  check(32'(bus.timer_period));
    expect_val({tag, "_lennz"}, 32'h0);   check(32'(bus.length_nonzero));
    expect_val({tag, "_pulse"}, 32'h0);   check(32'(bus.pulse_on));
    expect_val({tag, "_envctl"}, 32'h0);  check(32'(bus.env_ctl));
    expect_val({tag, "_sweep"}, 32'h0);
    check(32'({bus.sweep_enable, bus.sweep_negate, bus.sweep_div_period,
               bus.sweep_shift, bus.sweep_load, bus.env_start}));
  endtask

  initial begin
    int n, hi, lo, exp_n;
    rst = 1'b1;
    bus.cpu_clk_en = 1'b1;   bus.apu_clk_en = 1'b0;  bus.half_clk_en = 1'b0;
    bus.reg_we = 1'b0;       bus.reg_addr = 2'd0;    bus.reg_data = 8'h00;
    bus.channel_en = 1'b0;   bus.sweep_change = 1'b0;
    bus.sweep_period = 11'h0; bus.sweep_mute = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    bus.channel_en = 1'b1;
    tick();

    // Tone: duty2, period 0x10, length index 1 (254).
    write_reg(2'd0, 8'h80);
    expect_val("reg0_envctl", 32'h00);   check(32'(bus.env_ctl));
    write_reg(2'd2, 8'h10);
    expect_val("reg2_period", 32'h010);  check(32'(bus.timer_period));
    write_reg(2'd3, 8'h08);
    expect_val("reg3_period", 32'h010);  check(32'(bus.timer_period));
    expect_val("reg3_envstart", 32'h1);  check(32'(bus.env_start));
    expect_val("reg3_lennz", 32'h1);     check(32'(bus.length_nonzero));
    tick();
    expect_val("envstart_clear", 32'h0); check(32'(bus.env_start));

    run_until(1'b0, 400, n);
    run_until(1'b1, 400, n);
    expect_val("tone_sync", 32'h1);      check(32'(bus.pulse_on));
    expect_val("tone_high", 32'd136);
    run_until(1'b0, 400, hi);
    check(32'(hi));
    expect_val("tone_low", 32'd136);
    run_until(1'b1, 400, lo);
    check(32'(lo));
    bus.sweep_mute = 1'b1;
    expect_val("mute_on", 32'h0);
    tick();
    check(32'(bus.pulse_on));
    bus.sweep_mute = 1'b0;
    expect_val("mute_off", 32'h1);
    tick();
    check(32'(bus.pulse_on));

    // Length runs out on the 254th half-frame clock.
    for (int i = 1; i <= 254; i++) begin
      expect_val("len_count", (i < 254) ? 32'h1 : 32'h0);
      half_pulse();
      check(32'(bus.length_nonzero));
    end
    expect_val("len_pulse_off", 32'h0);
    tick();
    check(32'(bus.pulse_on));

    // Halt freezes the counter; index 3 loads 2.
    write_reg(2'd0, 8'hA0);
    write_reg(2'd3, 8'h18);
    for (int i = 0; i < 3; i++) begin
      expect_val("halt_hold", 32'h1);
      half_pulse();
      check(32'(bus.length_nonzero));
    end
    write_reg(2'd0, 8'h80);
    expect_val("unhalt_dec1", 32'h1);
    half_pulse();
    check(32'(bus.length_nonzero));
    expect_val("unhalt_dec2", 32'h0);
    half_pulse();
    check(32'(bus.length_nonzero));

    // Channel disable mid-tone.
    write_reg(2'd3, 8'h08);
    bus.channel_en = 1'b0;
    expect_val("dis_lennz", 32'h0);
    tick();
    check(32'(bus.length_nonzero));
    expect_val("dis_pulse", 32'h0);
    tick();
    check(32'(bus.pulse_on));
    expect_val("dis_load_blocked", 32'h0);
    write_reg(2'd3, 8'h08);
    check(32'(bus.length_nonzero));
    bus.channel_en = 1'b1;
    expect_val("reen_still_zero", 32'h0);
    tick();
    check(32'(bus.length_nonzero));

    // Sweep period updates and CPU priority.
    bus.sweep_change = 1'b1;
    bus.sweep_period = 11'h123;
    expect_val("sweep_load_period", 32'h123);
    tick();
    check(32'(bus.timer_period));
    bus.sweep_period = 11'h7FF;
    expect_val("reg2_beats_sweep", 32'h155);
    write_reg(2'd2, 8'h55);
    check(32'(bus.timer_period));
    expect_val("reg3_beats_sweep", 32'h555);
    write_reg(2'd3, 8'h05);
    check(32'(bus.timer_period));
    bus.sweep_change = 1'b0;
    bus.cpu_clk_en = 1'b0;
    expect_val("no_cpu_en_no_write", 32'h555);
    write_reg(2'd2, 8'hAA);
    check(32'(bus.timer_period));
    bus.cpu_clk_en = 1'b1;

    // Sweep register fields and one-cycle strobes.
    expect_val("reg1_fields", 32'b1_1_010_001_1);
    write_reg(2'd1, 8'hA9);
    check(32'({bus.sweep_enable, bus.sweep_negate, bus.sweep_div_period,
               bus.sweep_shift, bus.sweep_load}));
    expect_val("sweep_load_clear", 32'h0);
    tick();
    check(32'(bus.sweep_load));
    expect_val("env_start_pulse", 32'h1);
    write_reg(2'd3, 8'h08);
    check(32'(bus.env_start));
    expect_val("env_start_clear", 32'h0);
    tick();
    check(32'(bus.env_start));
    expect_val("reg0_envctl_3f", 32'h3F);
    write_reg(2'd0, 8'h3F);
    check(32'(bus.env_ctl));

    // Asynchronous reset clears outputs without waiting for an edge.
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    tick();
    rst = 1'b0;
    tick();

    // Length load coinciding with a decrementing half-frame clock.
    write_reg(2'd0, 8'h80);
    write_reg(2'd3, 8'h00);
`ifdef PULSE_LEN_WRITE_QUIRK_EN
    exp_n = 9;
`else
    exp_n = 254;
`endif
    expect_val("coinc_period", 32'h200);
    expect_val("coinc_envstart", 32'h1);
    bus.half_clk_en = 1'b1;
    write_reg(2'd3, 8'h0A);
    bus.half_clk_en = 1'b0;
    check(32'(bus.timer_period));
    check(32'(bus.env_start));
    expect_val("coinc_len_count", 32'(exp_n));
    n = 0;
    while (bus.length_nonzero === 1'b1 && n < 300) begin
      half_pulse();
      n++;
    end
    check(32'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_timer_seq.md
Name: pulse_timer_seq

Overview:
- Pulse-channel core that sits around the sweep unit. It decodes the channel's four CPU registers and holds the 11-bit timer period; the sweep unit reads that period and writes updates back.
- Runs the period timer, the 8-step duty sequencer and the length counter.
- Produces the gated 1-bit pulse level consumed by the channel's envelope/mixer stage.

Parameters:
- LEN_W, 8, length-counter width; fixed at 8 for NES tables.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_clk_en  in  1  one-cycle strobe per CPU cycle
- apu_clk_en  in  1  one-cycle strobe every second CPU cycle; timer tick
- half_clk_en  in  1  frame-counter half-frame strobe; length clock
- reg_we  in  1  register write strobe, qualified by cpu_clk_en
- reg_addr  in  2  0=$4000/4, 1=$4001/5, 2=$4002/6, 3=$4003/7
- reg_data  in  8  write data
- channel_en  in  1  $4015 enable bit for this channel
- sweep_change  in  1  sweep unit request to replace the period
- sweep_period  in  11  new period from the sweep unit
- sweep_mute  in  1  sweep mute
- timer_period  out  11  current period register, to the sweep unit
- sweep_enable, sweep_negate  out  1 each  reg1 bits 7 and 3
- sweep_div_period  out  3  reg1[6:4]
- sweep_shift  out  3  reg1[2:0]
- sweep_load  out  1  one-clk pulse on every reg1 write
- env_ctl  out  6  reg0[5:0] (halt/loop, constant flag, volume)
- env_start  out  1  one-clk pulse on every reg3 write
- length_nonzero  out  1  length counter != 0
- pulse_on  out  1  gated duty level

Behaviour:
- Reset (async, rst=1): all registers, timer, step, length and every output = 0.
- Register writes take effect on the clk edge where reg_we & cpu_clk_en. Data is visible on outputs the next cycle.
  - reg0: duty = [7:6]; length halt = [5]; env_ctl <= [5:0].
  - reg1: sweep fields latched; sweep_load = 1 for exactly that cycle.
  - reg2: timer_period[7:0] <= data.
  - reg3, all of the following:
    - timer_period[10:8] <= data[2:0]
    - step <= 0
    - env_start pulses
    - if channel_en, length <= LEN_TABLE[data[7:3]]
- Period update priority: a reg2/reg3 write wins over sweep_change in the same cycle. Otherwise sweep_change=1 loads sweep_period on that edge.
- Timer: 11-bit down counter, advanced only on apu_clk_en.
  - Value 0: reload timer_period and advance step (7 wraps to 0).
  - Otherwise: decrement.
  - Step period = (timer_period+1) APU ticks = 2*(timer_period+1) CPU cycles.
- Duty waveforms, step 0..7 left to right: duty0 01000000, duty1 01100000, duty2 01111000, duty3 10011111.
- LEN_TABLE, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Length counter:
  - On half_clk_en: if !halt and length != 0, decrement. Saturates at 0.
  - channel_en=0 forces length to 0 every cycle and blocks loads.
  - A reg3 load coinciding with half_clk_en: load wins unless the optional feature is enabled.
- pulse_on is registered, 1-cycle latency: duty bit & length_nonzero & ~sweep_mute.
- No state is retained across reset mid-operation; timer and step restart from 0.

Optional Feature:
- Macro: PULSE_LEN_WRITE_QUIRK_EN.
- Defined: a reg3 write in the same cycle as a half_clk_en that decrements a nonzero counter is ignored for the length field, and the decrement proceeds. Period, step and env_start still update.
- Undefined: the load always wins.

Test Plan:
- Write reg0=0x80 (duty2), reg2=0x10, reg3=0x08 (len idx1), channel_en=1 -> pulse_on high for steps 1-4, i.e. 4*34=136 CPU cycles high and 136 low, repeating.
- After the above, halt=0, issue 254 half_clk_en -> length_nonzero falls on the 254th; pulse_on=0 the cycle after.
- Drop channel_en mid-tone -> length_nonzero=0 and pulse_on=0 within 2 cycles; a reg3 write while disabled leaves length=0.
- sweep_change with sweep_period=0x123 -> timer_period=0x123 next cycle. Same cycle also writing reg2=0x55 -> timer_period[7:0]=0x55, and sweep_period is discarded.
- Writes to reg1=0xA9 and reg3 -> sweep_enable=1, div=2, negate=1, shift=1. sweep_load and env_start each high for exactly one cycle.
- Assert rst mid-sequence -> all outputs 0 immediately. Afterwards, reg3 with half_clk_en coincident: len=254 without the macro; with the macro, the old count minus 1.
